// File: rtl/seq_frame_tx.sv
// Bit-serial frame transmitter: sync pattern, payload MSB first, even parity bit, then an idle gap.
// One payload word per frame is accepted over a valid/ready handshake while idle.
module seq_frame_tx #(
    parameter logic [15:0] SYNC_PATTERN = 16'b100111,
    parameter int unsigned SYNC_LEN     = 6,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int unsigned MAX_CNT = (MAX_SD > GAP_CYCLES) ? MAX_SD : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned SR_W    = SYNC_LEN + DATA_W;

    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSync, StData, StParity, StGap} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  shreg;
    logic             parity;
    logic [SR_W-1:0]  frame_word;

    // Sync and payload share one shift register so the line is always its MSB.
    assign frame_word = {SYNC_PATTERN[SYNC_LEN-1:0], in_data};
    assign in_ready   = (state == StIdle) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        state     <= StSync;
                        cnt       <= SYNC_LOAD;
                        out       <= frame_word[SR_W-1];
                        shreg     <= frame_word << 1;
                        parity    <= ^in_data;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StSync: begin
                    out   <= shreg[SR_W-1];
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        state <= StData;
                        cnt   <= DATA_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StData: begin
                    if (cnt == '0) begin
                        state      <= StParity;
                        out        <= parity;
                        frame_done <= 1'b1;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        out   <= shreg[SR_W-1];
                        shreg <= shreg << 1;
                    end
                end
                StParity: begin
                    out        <= 1'b0;
                    out_valid  <= 1'b0;
                    frame_done <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        state <= StGap;
                        cnt   <= GAP_LOAD;
                    end
                end
                StGap: begin
                    if (cnt == '0) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: directed and random frames checked against a bit-level frame model.
module tb_seq_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] in_data;
    logic       in_valid, in_ready, out, out_valid, busy, frame_done;
    logic [3:0] v_in_data;
    logic       v_in_valid, v_in_ready, v_out, v_out_valid, v_busy, v_frame_done;

    int checks = 0;
    int errors = 0;

    seq_frame_tx dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    seq_frame_tx #(
        .SYNC_PATTERN (16'b1011),
        .SYNC_LEN     (4),
        .DATA_W       (4),
        .GAP_CYCLES   (0)
    ) dut_v (
        .clk        (clk),
        .reset      (reset),
        .in_data    (v_in_data),
        .in_valid   (v_in_valid),
        .in_ready   (v_in_ready),
        .out        (v_out),
        .out_valid  (v_out_valid),
        .busy       (v_busy),
        .frame_done (v_frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit i of a frame: sync MSB first, payload MSB first, then the even-parity bit.
    function automatic logic model_bit(input logic [15:0] pat, input int slen, input int dw,
                                       input logic [31:0] data, input int i);
        int ones;
        ones = 0;
        if (i < slen) return pat[slen-1-i];
        if (i < slen + dw) return data[dw-1-(i-slen)];
        for (int k = 0; k < dw; k++) ones += int'(data[k]);
        return logic'(ones % 2);
    endfunction

    task automatic offer(input logic [7:0] data, input bit keep);
        int t;
        t = 0;
        in_data  = data;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(t < 40), 1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic expect_frame(input logic [7:0] data, input bit pulse);
        for (int i = 0; i < 15; i++) begin
            check("out", 32'(out), 32'(model_bit(16'b100111, 6, 8, 32'(data), i)));
            check("out_valid", 32'(out_valid), 1);
            check("frame_done", 32'(frame_done), 32'(i == 14));
            check("busy", 32'(busy), 1);
            check("in_ready_busy", 32'(in_ready), 0);
            if (pulse) begin
                in_valid = (i == 2 || i == 9);
                in_data  = 8'($urandom);
            end
            @(negedge clk);
        end
        if (pulse) in_valid = 1'b0;
    endtask

    task automatic expect_gap();
        for (int g = 0; g < 2; g++) begin
            check("gap_out_valid", 32'(out_valid), 0);
            check("gap_out", 32'(out), 0);
            check("gap_busy", 32'(busy), 1);
            check("gap_in_ready", 32'(in_ready), 0);
            check("gap_frame_done", 32'(frame_done), 0);
            @(negedge clk);
        end
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int t;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        v_in_valid = 1'b0;
        v_in_data  = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_v_in_ready", 32'(v_in_ready), 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        offer(8'hA5, 1'b0); expect_frame(8'hA5, 1'b0); expect_gap();
        offer(8'h01, 1'b0); expect_frame(8'h01, 1'b0); expect_gap();
        offer(8'hFF, 1'b0); expect_frame(8'hFF, 1'b0); expect_gap();
        offer(8'h00, 1'b0); expect_frame(8'h00, 1'b0); expect_gap();

        // Back-to-back with in_valid held high throughout.
        offer(8'h3C, 1'b1); expect_frame(8'h3C, 1'b0); expect_gap();
        offer(8'hC3, 1'b0); expect_frame(8'hC3, 1'b0); expect_gap();

        // in_valid pulses mid-frame must be ignored.
        d = 8'($urandom);
        offer(d, 1'b0); expect_frame(d, 1'b1); expect_gap();

        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            offer(d, 1'b0); expect_frame(d, 1'b0); expect_gap();
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("idle_wait_ready", 32'(in_ready), 1);
                check("idle_wait_valid", 32'(out_valid), 0);
            end
        end

        // Asynchronous reset in the middle of the payload.
        d = 8'($urandom);
        offer(d, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("pre_abort_out", 32'(out), 32'(model_bit(16'b100111, 6, 8, 32'(d), i)));
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check("abort_out", 32'(out), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_frame_done", 32'(frame_done), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_hold_done", 32'(frame_done), 0);
            check("abort_hold_valid", 32'(out_valid), 0);
        end
        reset = 1'b0;
        #1;
        check("abort_release_ready", 32'(in_ready), 1);
        @(negedge clk);
        offer(8'h5A, 1'b0); expect_frame(8'h5A, 1'b0); expect_gap();

        // Variant: 4-bit sync 1011, 4-bit payload, no gap; in_valid held for two frames.
        v_in_data  = 4'h9;
        v_in_valid = 1'b1;
        t = 0;
        while (v_in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("v_accept_timeout", 32'(t < 40), 1);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            check("v_out", 32'(v_out), 32'(model_bit(16'b1011, 4, 4, 32'h9, i)));
            check("v_out_valid", 32'(v_out_valid), 1);
            check("v_frame_done", 32'(v_frame_done), 32'(i == 8));
            @(negedge clk);
        end
        check("v_idle_valid", 32'(v_out_valid), 0);
        check("v_idle_ready", 32'(v_in_ready), 1);
        check("v_idle_busy", 32'(v_busy), 0);
        @(negedge clk);
        check("v_next_sync_valid", 32'(v_out_valid), 1);
        check("v_next_sync_bit", 32'(v_out), 32'(model_bit(16'b1011, 4, 4, 32'h9, 0)));
        v_in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("v_final_idle", 32'(v_in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Bit-serial frame transmitter that feeds our serial sequence-detector receivers.
- Accepts one parallel payload word per frame over a valid/ready handshake.
- Emits the frame on a single-bit line: sync pattern, payload, even-parity bit, then a forced idle gap.
- The default sync pattern 100111 is the sequence our detector FSM recognises, so its match marks the start of payload on the receive end.

## Interface
Parameters:
- SYNC_PATTERN, 6'b100111: sync bits, sent MSB first.
- SYNC_LEN, 6: number of valid bits in SYNC_PATTERN; legal range 1..16.
- DATA_W, 8: payload width; legal range 1..32.
- GAP_CYCLES, 2: forced idle cycles after each parity bit; legal range 0..255.

Ports (clock and reset first):
- clk, input, 1: clock, rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- in_data, input, DATA_W: payload word; sampled only on acceptance.
- in_valid, input, 1: payload offered.
- in_ready, output, 1: transmitter can accept a payload.
- out, output, 1: serial line; 0 whenever out_valid=0.
- out_valid, output, 1: out carries a frame bit this cycle.
- busy, output, 1: high in every state except IDLE.
- frame_done, output, 1: one-cycle pulse, high in the cycle the parity bit is driven.

## Operation
- States and their transitions:
  - IDLE → SYNC on acceptance (in_valid & in_ready at a clk edge).
  - SYNC → DATA after SYNC_LEN cycles.
  - DATA → PARITY after DATA_W cycles.
  - PARITY → GAP after 1 cycle, or → IDLE directly if GAP_CYCLES=0.
  - GAP → IDLE after GAP_CYCLES cycles.
- Reset values, held while reset is asserted:
  - state = IDLE.
  - out = 0, out_valid = 0, frame_done = 0, busy = 0.
  - in_ready = 0 (forced low while reset=1).
  - Shift register and counters = 0.
- in_ready = (state==IDLE) & !reset, combinational from state.
- On acceptance:
  - in_data is latched into the shift register.
  - Parity = XOR of in_data is computed and latched.
  - in_data is don't-care afterwards.
- in_valid outside IDLE is ignored. No acceptance and no queuing; the source holds in_valid until in_ready.
- SYNC: out = SYNC_PATTERN[SYNC_LEN-1] down to SYNC_PATTERN[0], one bit per cycle, out_valid=1.
- DATA: out = latched payload MSB first (bit DATA_W-1 first), out_valid=1.
- PARITY: out = even parity, so the total count of 1s across payload and parity is even. out_valid=1 and frame_done=1.
- GAP: out=0, out_valid=0, busy=1, in_ready=0.
- Counter: a single down-counter, width clog2(max(SYNC_LEN,DATA_W,GAP_CYCLES)+1), reloaded on each state entry.
- Reset mid-frame:
  - The frame is aborted immediately (asynchronous) and not resumed.
  - No frame_done is issued for the aborted frame.
  - Transmission resumes from IDLE after reset deasserts.
- The payload is not bit-stuffed. Sync emulation inside the payload is the receiver's concern; parity is the only integrity check.

## Timing
- All outputs except in_ready are registered; they change only on clk rising edges, or asynchronously on reset.
- Acceptance at edge N: the first sync bit appears on out in cycle N+1.
- Frame occupancy: SYNC_LEN+DATA_W+1 consecutive out_valid=1 cycles. This is 15 cycles at the defaults.
- Parity in cycle P:
  - GAP occupies P+1..P+GAP_CYCLES.
  - IDLE begins at P+GAP_CYCLES+1, with in_ready=1 in that cycle.
  - Earliest next sync bit is at P+GAP_CYCLES+2.
- Minimum out_valid=0 run between back-to-back frames: GAP_CYCLES+1 cycles (3 at the defaults).
- in_valid held high continuously gives maximum throughput: one frame per SYNC_LEN+DATA_W+GAP_CYCLES+2 cycles.

## Test plan
- Reset, then single frame, defaults:
  - Stimulus: in_data=0xA5, accepted at edge N.
  - out over cycles N+1..N+15 = 1,0,0,1,1,1, then 1,0,1,0,0,1,0,1, then parity 0.
  - frame_done high only in cycle N+15.
  - out_valid=0 at N+16 and N+17; in_ready=1 at N+18.
- Parity check:
  - in_data=0x01 → parity bit 1.
  - in_data=0xFF → parity bit 0.
  - in_data=0x00 → line after sync is all zeros, with out_valid=1 for all 9 cycles.
- Back-to-back: in_valid held high with 0x3C then 0xC3 → exactly 3 out_valid=0 cycles between the two frames; both payloads exact.
- in_valid pulsed in cycles N+3 and N+10 during an active frame → no acceptance; the frame is unchanged; in_ready stays 0 until IDLE.
- Asynchronous reset asserted mid-DATA, between clock edges:
  - out, out_valid and in_ready drop to 0 immediately; no frame_done.
  - After release, a new 0x5A frame transmits correctly from its first sync bit.
- Parameter variant SYNC_PATTERN=4'b1011, SYNC_LEN=4, DATA_W=4, GAP_CYCLES=0, in_data=0x9:
  - out = 1,0,1,1, then 1,0,0,1, then 0.
  - Next frame's first sync bit arrives 2 cycles after its parity bit.
